// File: rtl/rom_stream_pkg.sv
// -----------------------------------------------------------------------------
// rom_stream_pkg
// Shared definitions for the ROM stream reader:
//   - reader FSM state encoding
//   - default ROM geometry (8 words x 2 bits), shared with the ROM itself
//   - depth of the output skid FIFO and the width of its occupancy count
// -----------------------------------------------------------------------------
package rom_stream_pkg;

    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 2;

    // Two entries cover one word already in the FIFO plus one word in flight
    // from the ROM, which is enough for full throughput under backpressure.
    localparam int FIFO_DEPTH = 2;
    localparam int OCC_W      = 2;   // holds 0..FIFO_DEPTH

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/rom_skid_fifo.sv
// -----------------------------------------------------------------------------
// rom_skid_fifo
// Two-entry FIFO that catches words returning from the ROM so the downstream
// consumer can stall without losing data. The head entry is presented
// directly, so it stays stable until popped.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset (flushes the FIFO)
//   push      in   write push_data at the next edge
//   push_data in   DATA_W word to write
//   pop       in   discard the head entry at the next edge (only when occ!=0)
//   head_data out  current head entry
//   occ       out  number of valid entries (0..2)
// -----------------------------------------------------------------------------
module rom_skid_fifo
    import rom_stream_pkg::*;
#(
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;

        // On a full FIFO with push and pop together the write lands in the
        // slot being popped this same edge, so nothing live is overwritten.
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occ       = occ_q;

endmodule

// File: rtl/rom_stream_reader.sv
// -----------------------------------------------------------------------------
// rom_stream_reader
// Reads a burst of consecutive words from a synchronous ROM (1-cycle read
// latency) and presents them as a valid/ready stream, with a start/busy/done
// handshake towards a controller.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request a burst (sampled only when idle)
//   start_addr in   first ROM address of the burst
//   count      in   number of words in the burst (0 = done pulse only)
//   rom_addr   out  registered address to the ROM
//   rom_data   in   ROM read data, valid one cycle after rom_addr
//   out_data   out  stream payload (FIFO head)
//   out_valid  out  payload valid
//   out_ready  in   consumer accepts the payload
//   busy       out  burst in progress
//   done       out  one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int LVL_W = OCC_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;

    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] head_data;
    logic              pop;
    logic              issue;
    logic              drain_done;
    logic [LVL_W-1:0]  level;

    rom_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rom_data),
        .pop       (pop),
        .head_data (head_data),
        .occ       (occ)
    );

    assign out_valid = (occ != '0);
    assign pop       = out_valid & out_ready;

    // Words committed to the FIFO once this cycle's pop is taken out. A new
    // read is only counted when its data is guaranteed a free slot on arrival.
    assign level = LVL_W'(occ) + LVL_W'(inflight_q) - LVL_W'(pop);
    assign issue = (state_q == ST_READ) && (level < LVL_W'(2));

    // The last beat leaves the FIFO at the coming edge and nothing is still
    // on its way from the ROM.
    assign drain_done = (state_q == ST_DRAIN) && !inflight_q &&
                        ((occ == '0) || ((occ == OCC_W'(1)) && pop));

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d     = ST_READ;
                        rom_addr_d  = start_addr;
                        remaining_d = count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // Without an issue rom_addr holds; the ROM re-reads the same
                // word but that read is never pushed.
                if (issue) begin
                    rom_addr_d  = rom_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W + 1)'(1);
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign out_data = head_data;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

    localparam int AW = 3;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // Synchronous ROM, contents rom[i] = i % 4.
    logic [DW-1:0] rom [8];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- behavioural model + compare process ----------------
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    logic [AW-1:0] addr_log [$];
    logic [DW-1:0] e_word;
    int  done_exp_cyc    = -1;
    int  first_valid_cyc = -1;
    int  start_cyc       = -1;
    bit  model_busy      = 1'b0;
    bit  prev_stall      = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            done_exp_cyc = -1;
            model_busy   = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            chk("done", int'(done), int'(cyc == done_exp_cyc));
            if (cyc == done_exp_cyc) model_busy = 1'b0;
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(prev_data));
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", int'(out_data), -1);
                end else begin
                    e_word = exp_q.pop_front();
                    chk("beat", int'(out_data), int'(e_word));
                    got_q.push_back(out_data);
                    if (exp_q.size() == 0) done_exp_cyc = cyc + 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (busy && (addr_log.size() == 0 || addr_log[$] != rom_addr))
                addr_log.push_back(rom_addr);
            // A start is honoured only when no burst is outstanding.
            if (start && !model_busy) begin
                got_q.delete();
                addr_log.delete();
                first_valid_cyc = -1;
                start_cyc       = cyc;
                if (count == 0) begin
                    done_exp_cyc = cyc + 1;
                end else begin
                    model_busy = 1'b1;
                    for (int i = 0; i < int'(count); i++)
                        exp_q.push_back(rom[3'(int'(start_addr) + i)]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_burst(input logic [AW-1:0] sa, input logic [AW:0] cnt,
                             input int mode, input int stray_at, output int done_cyc);
        bit seen = 1'b0;
        done_cyc = -1;
        @(posedge clk); #1;
        start_addr = sa; count = cnt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            if (k == stray_at) begin
                start = 1'b1; start_addr = 3'd5; count = 4'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k == 0 && cnt != 0) chk("busy_on", int'(busy), 1);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
                chk("busy_off", int'(busy), 0);
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) chk("done_timeout", 0, 1);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("leftover_beats", exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
    endtask

    initial begin
        int dc;
        int lit0 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int litw [4] = '{2, 3, 0, 1};
        int lita [4] = '{6, 7, 0, 1};
        int litb [5] = '{1, 2, 3, 0, 1};
        int lits [6] = '{2, 3, 0, 1, 2, 3};

        for (int i = 0; i < 8; i++) rom[i] = DW'(i % 4);
        rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        // Burst from 0, full throughput.
        run_burst(3'd0, 4'd8, 0, -1, dc);
        chk("b0_beats", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk("b0_lit", int'(got_q[i]), lit0[i]);
        chk("b0_first_valid_lat", first_valid_cyc - start_cyc, 3);
        chk("b0_done_lat", dc - start_cyc, 11);

        // Address wrap.
        run_burst(3'd6, 4'd4, 0, -1, dc);
        chk("wrap_beats", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("wrap_lit", int'(got_q[i]), litw[i]);
        chk("wrap_addrs", addr_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("wrap_addr", int'(addr_log[i]), lita[i]);
        chk("wrap_done_lat", dc - start_cyc, 7);

        // Backpressure: ready high one cycle in three.
        run_burst(3'd1, 4'd5, 1, -1, dc);
        chk("bp_beats", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("bp_lit", int'(got_q[i]), litb[i]);

        // Zero count.
        run_burst(3'd4, 4'd0, 0, -1, dc);
        chk("zero_beats", got_q.size(), 0);
        chk("zero_done_lat", dc - start_cyc, 1);

        // Start pulsed mid-burst must be ignored.
        run_burst(3'd2, 4'd6, 0, 3, dc);
        chk("stray_beats", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) chk("stray_lit", int'(got_q[i]), lits[i]);

        // Reset two cycles after the first beat.
        @(posedge clk); #1;
        start_addr = 3'd0; count = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (first_valid_cyc >= 0) break;
        end
        chk("rb_first_valid_seen", int'(first_valid_cyc >= 0), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        repeat (3) @(posedge clk);
        run_burst(3'd3, 4'd2, 0, -1, dc);
        chk("after_rst_beats", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("after_rst_b0", int'(got_q[0]), 3);
            chk("after_rst_b1", int'(got_q[1]), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
